// File: rtl/layer_controller.sv
// layer_controller: drives a shared neuron unit across one dense layer,
// banking each (optionally ReLU'd) result and tracking the running argmax.
module layer_controller #(
    parameter int  OUT_SIZE  = 10,
    parameter int  WIDTH_OUT = 32,
    parameter int  RELU      = 1,
    localparam int IDX_W     = $clog2(OUT_SIZE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          layer_go,
    input  logic                          neuron_done,
    input  logic signed [WIDTH_OUT-1:0]   neuron_result,
    output logic                          neuron_go,
    output logic [IDX_W-1:0]              neuron_sel,
    output logic                          layer_busy,
    output logic                          layer_done,
    output logic [WIDTH_OUT*OUT_SIZE-1:0] layer_out,
    output logic [IDX_W-1:0]              max_index,
    output logic signed [WIDTH_OUT-1:0]   max_value
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_SIZE - 1);
    localparam logic signed [WIDTH_OUT-1:0] MOST_NEG =
        {1'b1, {(WIDTH_OUT-1){1'b0}}};

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            sel_q, sel_d;
    logic [IDX_W-1:0]            max_idx_q, max_idx_d;
    logic signed [WIDTH_OUT-1:0] max_val_q, max_val_d;
    logic signed [WIDTH_OUT-1:0] cap_val;
    logic signed [WIDTH_OUT-1:0] bank_q [OUT_SIZE];
    logic                        capture;

    assign capture = (state_q == WAIT) && neuron_done;
    assign cap_val = (RELU != 0 && neuron_result < 0) ? '0 : neuron_result;

    always_comb begin
        state_d   = IDLE;
        sel_d     = sel_q;
        max_idx_d = max_idx_q;
        max_val_d = max_val_q;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
                if (layer_go) begin
                    state_d   = START;
                    sel_d     = '0;
                    max_idx_d = '0;
                    max_val_d = MOST_NEG;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                state_d = WAIT;
                if (neuron_done) begin
                    state_d = STORE;
                    // Strict compare keeps the lower index on ties
                    if (sel_q == '0 || cap_val > max_val_q) begin
                        max_idx_d = sel_q;
                        max_val_d = cap_val;
                    end
                end
            end
            STORE: begin
                if (sel_q == LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = START;
                    sel_d   = sel_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                sel_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
            for (int k = 0; k < OUT_SIZE; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            max_idx_q <= max_idx_d;
            max_val_q <= max_val_d;
            if (capture) begin
                bank_q[sel_q] <= cap_val;
            end
        end
    end

    for (genvar k = 0; k < OUT_SIZE; k++) begin : g_out
        assign layer_out[(k+1)*WIDTH_OUT-1 -: WIDTH_OUT] = bank_q[k];
    end

    assign neuron_go  = (state_q == START);
    assign layer_done = (state_q == DONE);
    assign layer_busy = (state_q != IDLE);
    assign neuron_sel = sel_q;
    assign max_index  = max_idx_q;
    assign max_value  = max_val_q;

endmodule

// File: tb/tb_layer_controller.sv
// Directed bench for layer_controller: two instances (ReLU on/off) share
// stimulus from a small neuron-unit model answering two cycles after go.
module tb_layer_controller;

    logic               clk = 1'b0;
    logic               reset;
    logic               layer_go;
    logic               neuron_done;
    logic signed [31:0] neuron_result;

    logic               go_a, busy_a, done_a;
    logic               go_b, busy_b, done_b;
    logic [1:0]         sel_a, mi_a, sel_b, mi_b;
    logic [127:0]       out_a, out_b;
    logic signed [31:0] mv_a, mv_b;

    int total = 0;
    int bad   = 0;
    int res [4];
    int inj      = 0;
    int rst_mode = 0;
    int dk, ng;
    logic seen;

    always #5 clk = ~clk;

    layer_controller #(.OUT_SIZE(4), .WIDTH_OUT(32), .RELU(1)) u_a (
        .clk(clk), .reset(reset), .layer_go(layer_go),
        .neuron_done(neuron_done), .neuron_result(neuron_result),
        .neuron_go(go_a), .neuron_sel(sel_a), .layer_busy(busy_a),
        .layer_done(done_a), .layer_out(out_a),
        .max_index(mi_a), .max_value(mv_a)
    );

    layer_controller #(.OUT_SIZE(4), .WIDTH_OUT(32), .RELU(0)) u_b (
        .clk(clk), .reset(reset), .layer_go(layer_go),
        .neuron_done(neuron_done), .neuron_result(neuron_result),
        .neuron_go(go_b), .neuron_sel(sel_b), .layer_busy(busy_b),
        .layer_done(done_b), .layer_out(out_b),
        .max_index(mi_b), .max_value(mv_b)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input int a, input int b,
                                          input int c, input int d);
        return {d[31:0], c[31:0], b[31:0], a[31:0]};
    endfunction

    task automatic run_layer(output int done_k, output int ngo);
        int   dn_cnt;
        logic prev_go;
        dn_cnt  = 0;
        prev_go = 1'b0;
        ngo     = 0;
        done_k  = -1;
        @(negedge clk);
        layer_go = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            layer_go      = 1'b0;
            neuron_done   = 1'b0;
            neuron_result = 32'sh0BAD;
            if (dn_cnt > 0) begin
                dn_cnt--;
                if (dn_cnt == 0) begin
                    neuron_done   = 1'b1;
                    neuron_result = res[ngo-1];
                    chk("cap_sel", sel_a, ngo - 1);
                end
            end
            if (go_a) begin
                chk("go_width", prev_go, 1'b0);
                chk("go_sel", sel_a, ngo);
                ngo++;
                dn_cnt = 2;
                if (inj != 0) begin
                    layer_go      = 1'b1;
                    neuron_done   = 1'b1;
                    neuron_result = 32'sd1000;
                end
            end else if (inj != 0 && dn_cnt == 1) begin
                layer_go = 1'b1;
            end
            prev_go = go_a;
            if (rst_mode != 0 && ngo == 3 && dn_cnt == 1) begin
                reset = 1'b0;
                #1;
                chk("rst_go", go_a, 1'b0);
                chk("rst_done", done_a, 1'b0);
                chk("rst_busy", busy_a, 1'b0);
                chk("rst_sel", sel_a, 2'd0);
                chk("rst_out", out_a, 128'd0);
                chk("rst_mi", mi_a, 2'd0);
                chk("rst_mv", mv_a, 32'd0);
                done_k = -2;
                return;
            end
            if (done_a) begin
                done_k = k;
                break;
            end
        end
    endtask

    initial begin
        reset         = 1'b0;
        layer_go      = 1'b0;
        neuron_done   = 1'b0;
        neuron_result = '0;
        repeat (2) @(negedge clk);
        chk("reset_out", out_a, 128'd0);
        chk("reset_mi", mi_a, 2'd0);
        chk("reset_mv", mv_a, 32'd0);
        chk("reset_busy", busy_a, 1'b0);
        chk("reset_go", go_a, 1'b0);
        chk("reset_done", done_a, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy_a, 1'b0);

        res = '{5, -2, 9, 9};
        run_layer(dk, ng);
        chk("t1_lat", dk, 16);
        chk("t1_ngo", ng, 4);
        chk("t1_out", out_a, pack(5, 0, 9, 9));
        chk("t1_mi", mi_a, 2'd2);
        chk("t1_mv", mv_a, 32'sd9);
        chk("t1_raw_out", out_b, pack(5, -2, 9, 9));
        chk("t1_raw_mi", mi_b, 2'd2);
        repeat (3) @(negedge clk);
        chk("t1_hold_out", out_a, pack(5, 0, 9, 9));
        chk("t1_hold_mv", mv_a, 32'sd9);
        chk("t1_hold_busy", busy_a, 1'b0);

        res = '{-7, -3, -9, -4};
        run_layer(dk, ng);
        chk("t2_lat", dk, 16);
        chk("t2_raw_out", out_b, pack(-7, -3, -9, -4));
        chk("t2_raw_mi", mi_b, 2'd1);
        chk("t2_raw_mv", mv_b, -32'sd3);
        chk("t2_relu_out", out_a, 128'd0);
        chk("t2_relu_mi", mi_a, 2'd0);
        chk("t2_relu_mv", mv_a, 32'd0);

        inj = 1;
        res = '{5, -2, 9, 9};
        run_layer(dk, ng);
        inj = 0;
        chk("t3_lat", dk, 16);
        chk("t3_ngo", ng, 4);
        chk("t3_out", out_a, pack(5, 0, 9, 9));
        chk("t3_mi", mi_a, 2'd2);
        chk("t3_mv", mv_a, 32'sd9);

        rst_mode = 1;
        res = '{1, 2, 3, 4};
        run_layer(dk, ng);
        rst_mode = 0;
        chk("t4_aborted", dk, -2);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done_a | busy_a;
        end
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            seen = seen | done_a | busy_a | go_a;
        end
        chk("t4_no_done", seen, 1'b0);
        res = '{3, 8, -1, 2};
        run_layer(dk, ng);
        chk("t4_lat", dk, 16);
        chk("t4_out", out_a, pack(3, 8, 0, 2));
        chk("t4_mi", mi_a, 2'd1);
        chk("t4_mv", mv_a, 32'sd8);

        res = '{20, -5, 7, 1};
        run_layer(dk, ng);
        chk("t5a_mi", mi_a, 2'd0);
        chk("t5a_mv", mv_a, 32'sd20);
        res = '{1, 3, 2, 0};
        run_layer(dk, ng);
        chk("t5b_lat", dk, 16);
        chk("t5b_out", out_a, pack(1, 3, 2, 0));
        chk("t5b_mi", mi_a, 2'd1);
        chk("t5b_mv", mv_a, 32'sd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
